// File: rtl/audio_sample_scheduler_pkg.sv
// Shared types for the audio sample scheduler: stereo word, scheduler states and accumulator sizing.
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef struct packed {
    logic [AUDIO_W-1:0] l;
    logic [AUDIO_W-1:0] r;
  } stereo_sample_t;

  typedef enum logic [1:0] {IDLE, FETCH, PUSH} sched_state_t;

  // Bits needed so acc + rate never wraps before the wrap-around compare.
  function automatic int tick_acc_width(input longint clk_hz, input longint rate);
    return $clog2(clk_hz + rate);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO of stereo words; head is read straight from flops and a pop frees a slot
// for a push in the same cycle, so a full FIFO that is being drained never refuses a write.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk_pixel,
  input  logic           rst_n,
  input  logic           push,
  input  stereo_sample_t push_dat,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output stereo_sample_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  stereo_sample_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Derives the audio sample cadence from clk_pixel, steps the tone generator once per sample and
// buffers the stereo word for the packetizer; tick to out_valid is 4 cycles with an immediate generator.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int CLK_FREQ_HZ     = 25200000,
  parameter int SAMPLE_RATE     = 48000,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk_pixel,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clr_status,
  output logic                       gen_step,
  input  logic                       gen_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] gen_sample_l,
  input  logic [AUDIO_BIT_WIDTH-1:0] gen_sample_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AUDIO_BIT_WIDTH-1:0] out_sample_l,
  output logic [AUDIO_BIT_WIDTH-1:0] out_sample_r,
  output logic                       sample_tick,
  output logic                       overflow,
  output logic                       timeout,
  output logic [7:0]                 drop_count
);

  localparam int          ACC_NEED = tick_acc_width(CLK_FREQ_HZ, SAMPLE_RATE);
  localparam logic [31:0] RATE32   = 32'(SAMPLE_RATE);
  localparam logic [31:0] CLK32    = 32'(CLK_FREQ_HZ);
  localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT_CYCLES);

  if (ACC_NEED > 32 || AUDIO_BIT_WIDTH != AUDIO_W) begin : g_bad_cfg
    $error("audio_sample_scheduler: unsupported parameter set");
  end

  // Fractional cadence: wrapping by CLK_FREQ_HZ keeps the remainder, so the rate never drifts.
  logic [31:0] acc;
  logic [31:0] acc_sum;
  assign acc_sum = acc + RATE32;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      sample_tick <= 1'b0;
    end else if (acc_sum >= CLK32) begin
      acc         <= acc_sum - CLK32;
      sample_tick <= 1'b1;
    end else begin
      acc         <= acc_sum;
      sample_tick <= 1'b0;
    end
  end

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             step_nxt, load_cnt, capture, tmo_evt, mute_evt, push, tick_drop;
  logic             push_mute;
  stereo_sample_t   gen_dat, hold, push_dat, head;
  logic             fifo_full, fifo_empty, pop, fifo_drop;

  assign gen_dat.l = gen_sample_l;
  assign gen_dat.r = gen_sample_r;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = 1'b0;
    load_cnt  = 1'b0;
    capture   = 1'b0;
    tmo_evt   = 1'b0;
    mute_evt  = 1'b0;
    push      = 1'b0;
    tick_drop = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick && enable) begin
          state_nxt = FETCH;
          step_nxt  = 1'b1;
          load_cnt  = 1'b1;
        end else if (sample_tick) begin
          state_nxt = PUSH;
          mute_evt  = 1'b1;
        end
      end
      FETCH: begin
        tick_drop = sample_tick;
        // gen_valid during the step cycle itself still belongs to the previous sample.
        if (gen_valid && !gen_step) begin
          capture   = 1'b1;
          state_nxt = PUSH;
        end else if (tmo_cnt <= CNT_W'(1)) begin
          tmo_evt   = 1'b1;
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        tick_drop = sample_tick;
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      gen_step  <= 1'b0;
      tmo_cnt   <= '0;
      hold      <= '0;
      push_mute <= 1'b0;
    end else begin
      gen_step <= step_nxt;
      if (load_cnt)                             tmo_cnt <= CNT_INIT;
      else if (state == FETCH && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (capture) hold <= gen_dat;
      if (mute_evt)      push_mute <= 1'b1;
      else if (load_cnt) push_mute <= 1'b0;
    end
  end

  // A timeout leaves hold untouched, so the last good sample is repeated.
  assign push_dat = push_mute ? '0 : hold;

  assign pop       = out_valid && out_ready;
  assign fifo_drop = push && fifo_full && !pop;

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_valid    = !fifo_empty;
  assign out_sample_l = head.l;
  assign out_sample_r = head.r;

  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  assign drop_inc = {1'b0, tick_drop} + {1'b0, fifo_drop};
  assign drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      drop_count <= '0;
    end else if (clr_status) begin
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop_inc != 2'd0) overflow <= 1'b1;
      if (tmo_evt)          timeout  <= 1'b1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule
